// File: rtl/ram_pp_ctrl.sv
// rtl/ram_pp_ctrl.sv - ping-pong bank controller around a dual-port RAM
// Writes fill one bank via port A while completed banks stream out via port B.
module ram_pp_ctrl #(
  parameter int Addr_Width = 6,
  parameter int Word_Width = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [Word_Width-1:0] in_data_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [Word_Width-1:0] out_data_o,
  output logic                  out_last_o,
  output logic [1:0]            bank_full_o,
  output logic                  ram_cena_o,
  output logic                  ram_wena_o,
  output logic                  ram_oena_o,
  output logic [Addr_Width-1:0] ram_addra_o,
  output logic [Word_Width-1:0] ram_dataa_o,
  output logic                  ram_cenb_o,
  output logic                  ram_wenb_o,
  output logic                  ram_oenb_o,
  output logic [Addr_Width-1:0] ram_addrb_o,
  input  logic [Word_Width-1:0] ram_datab_i
);
  localparam int PW = Addr_Width - 1;
  localparam logic [PW-1:0] LastPtr = '1;

  logic                  r_wr_bank, r_rd_bank;
  logic [PW-1:0]         r_wr_ptr, r_rd_ptr;
  logic [1:0]            r_full;
  logic [Word_Width-1:0] r_buf_data [2];
  logic [1:0]            r_buf_last;
  logic                  r_head;
  logic [1:0]            r_cnt;
  logic                  r_pend, r_pend_last;

  logic       w_wr, w_rd, w_pop;
  logic [1:0] w_full_nxt;

  assign in_ready_o = ~rst_i & ~r_full[r_wr_bank];
  assign w_wr       = in_valid_i & in_ready_o;
  assign w_pop      = (r_cnt != 2'd0) & out_ready_i;
  // Count the slot freed by this cycle's pop so a drained buffer keeps 1 word/cycle.
  assign w_rd = r_full[r_rd_bank] &
                (({1'b0, r_cnt} + {2'b00, r_pend} - {2'b00, w_pop}) <= 3'd1);

  always_comb begin
    w_full_nxt = r_full;
    if (w_wr && r_wr_ptr == LastPtr) w_full_nxt[r_wr_bank] = 1'b1;
    if (w_rd && r_rd_ptr == LastPtr) w_full_nxt[r_rd_bank] = 1'b0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_bank     <= 1'b0;
      r_rd_bank     <= 1'b0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_full        <= 2'b00;
      r_buf_data[0] <= '0;
      r_buf_data[1] <= '0;
      r_buf_last    <= 2'b00;
      r_head        <= 1'b0;
      r_cnt         <= 2'd0;
      r_pend        <= 1'b0;
      r_pend_last   <= 1'b0;
    end else begin
      r_full <= w_full_nxt;
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
        if (r_wr_ptr == LastPtr) r_wr_bank <= ~r_wr_bank;
      end
      if (w_rd) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        if (r_rd_ptr == LastPtr) r_rd_bank <= ~r_rd_bank;
      end
      r_pend      <= w_rd;
      r_pend_last <= w_rd & (r_rd_ptr == LastPtr);
      // While a read is in flight at most one word is buffered, so the tail slot is free.
      if (r_pend) begin
        r_buf_data[r_head ^ r_cnt[0]] <= ram_datab_i;
        r_buf_last[r_head ^ r_cnt[0]] <= r_pend_last;
      end
      if (w_pop) r_head <= ~r_head;
      r_cnt <= r_cnt + {1'b0, r_pend} - {1'b0, w_pop};
    end
  end

  assign out_valid_o = (r_cnt != 2'd0);
  assign out_data_o  = r_buf_data[r_head];
  assign out_last_o  = (r_cnt != 2'd0) & r_buf_last[r_head];
  assign bank_full_o = r_full;

  assign ram_cena_o  = ~w_wr;
  assign ram_wena_o  = ~w_wr;
  assign ram_oena_o  = 1'b1;
  assign ram_addra_o = w_wr ? {r_wr_bank, r_wr_ptr} : '0;
  assign ram_dataa_o = w_wr ? in_data_i : '0;

  assign ram_cenb_o  = ~w_rd;
  assign ram_wenb_o  = 1'b1;
  assign ram_oenb_o  = 1'b0;
  assign ram_addrb_o = w_rd ? {r_rd_bank, r_rd_ptr} : '0;
endmodule

// File: tb/tb_ram_pp_ctrl.sv
// tb/tb_ram_pp_ctrl.sv - randomized bench for ram_pp_ctrl with a word-order reference model
module tb_ram_pp_ctrl;
  localparam int AW = 6;
  localparam int WW = 32;
  localparam int D  = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, out_valid, out_ready, out_last;
  logic [WW-1:0] in_data, out_data, ram_dataa, ram_datab;
  logic [1:0]    bank_full;
  logic          ram_cena, ram_wena, ram_oena, ram_cenb, ram_wenb, ram_oenb;
  logic [AW-1:0] ram_addra, ram_addrb;

  ram_pp_ctrl #(.Addr_Width(AW), .Word_Width(WW)) dut (
    .clk_i(clk), .rst_i(rst),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
    .out_last_o(out_last), .bank_full_o(bank_full),
    .ram_cena_o(ram_cena), .ram_wena_o(ram_wena), .ram_oena_o(ram_oena),
    .ram_addra_o(ram_addra), .ram_dataa_o(ram_dataa),
    .ram_cenb_o(ram_cenb), .ram_wenb_o(ram_wenb), .ram_oenb_o(ram_oenb),
    .ram_addrb_o(ram_addrb), .ram_datab_i(ram_datab)
  );

  always #5 clk = ~clk;

  logic [WW-1:0] mem [2*D];
  always @(posedge clk) begin
    if (!ram_cena && !ram_wena) mem[ram_addra] <= ram_dataa;
    if (!ram_cenb) ram_datab <= mem[ram_addrb];
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: every accepted word in order; only whole banks may come out.
  logic [WW-1:0] sent[$];
  int wr_cnt = 0, out_idx = 0, rd_cnt = 0, cyc = 0;
  int first_pop_cyc = 0, last_pop_cyc = 0, last_wr_cyc = 0;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      sent.delete();
      wr_cnt  = 0;
      out_idx = 0;
      rd_cnt  = 0;
    end else begin
      if (out_valid && out_ready) begin
        if (out_idx < sent.size()) check("out_data", out_data, sent[out_idx]);
        else check("out_extra", out_idx, sent.size());
        check("out_last", out_last, (out_idx % D) == D - 1);
        check("out_whole_bank", out_idx < (wr_cnt / D) * D, 1);
        if (out_idx == 0) first_pop_cyc = cyc;
        last_pop_cyc = cyc;
        out_idx++;
      end
      if (!ram_cenb) begin
        check("rd_addr", ram_addrb, rd_cnt % (2 * D));
        check("rd_whole_bank", rd_cnt < (wr_cnt / D) * D, 1);
        if (!ram_cena) check("bank_clash", ram_addra[AW-1] != ram_addrb[AW-1], 1);
        rd_cnt++;
      end
      if (in_valid && in_ready) begin
        check("wr_cen", ram_cena, 0);
        check("wr_wen", ram_wena, 0);
        check("wr_addr", ram_addra, wr_cnt % (2 * D));
        check("wr_data", ram_dataa, in_data);
        sent.push_back(in_data);
        wr_cnt++;
        last_wr_cyc = cyc;
      end
    end
  end

  int rdy_mode = 0;
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = 1'($urandom_range(1));
    endcase
  end

  int stalls = 0;

  task automatic send(input int n, input int pct, input bit seq);
    int done = 0;
    int guard = 0;
    while (done < n && guard < 20000) begin
      in_valid = ($urandom_range(99) < pct);
      in_data  = seq ? WW'(done) : $urandom;
      @(negedge clk);
      if (in_valid && in_ready) done++;
      else if (in_valid) stalls++;
      @(posedge clk);
      #1;
      guard++;
    end
    in_valid = 1'b0;
    check("send_timeout", done, n);
  endtask

  task automatic drain();
    int g = 0;
    while (out_idx != (wr_cnt / D) * D && g < 5000) begin
      @(posedge clk);
      #1;
      g++;
    end
    check("drain", out_idx, (wr_cnt / D) * D);
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_cena", ram_cena, 1);
    check("rst_wena", ram_wena, 1);
    check("rst_cenb", ram_cenb, 1);
    check("rst_addra", ram_addra, 0);
    check("rst_addrb", ram_addrb, 0);
    check("rst_dataa", ram_dataa, 0);
    check("rst_full", bank_full, 0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", in_ready, 1);
    @(posedge clk);
    #1;

    // One bank of 0..31 with a free-running consumer.
    rdy_mode = 1;
    send(32, 100, 1);
    @(negedge clk);
    check("full_one_bank", bank_full, 2'b01);
    drain();
    check("first_latency", first_pop_cyc - last_wr_cyc, 3);
    check("burst_rate", last_pop_cyc - first_pop_cyc, D - 1);
    check("full_cleared", bank_full, 2'b00);

    // Three banks back-to-back must never stall the writer.
    reset_dut();
    stalls = 0;
    send(96, 100, 0);
    drain();
    check("no_stall", stalls, 0);

    // Both banks fill under backpressure, then release.
    rdy_mode = 0;
    reset_dut();
    send(64, 100, 0);
    in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("both_full_block", in_ready, 0);
    end
    in_valid = 1'b0;
    check("both_full", bank_full, 2'b11);
    check("hold_valid", out_valid, 1);
    check("hold_data", out_data, sent[0]);
    rdy_mode = 1;
    g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (!(!ram_cenb && ram_addrb == AW'(D - 1)) && g < 200);
    check("last_read_seen", g < 200, 1);
    check("ready_at_last_read", in_ready, 0);
    @(negedge clk);
    check("ready_after_last_read", in_ready, 1);
    @(posedge clk);
    #1;
    drain();
    check("drain_64", out_idx, 64);

    // Random traffic; the trailing partial bank must stay put.
    reset_dut();
    rdy_mode = 2;
    send(1000, 70, 0);
    drain();
    rdy_mode = 1;
    repeat (60) @(posedge clk);
    #1;
    check("partial_held", out_idx, (1000 / D) * D);

    // Reset in the middle of a bank.
    rdy_mode = 0;
    reset_dut();
    send(32 + 17, 100, 0);
    rdy_mode = 1;
    g = 0;
    while (out_idx < 5 && g < 200) begin
      @(posedge clk);
      #1;
      g++;
    end
    check("five_read", out_idx >= 5, 1);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_in_ready", in_ready, 0);
    check("mid_rst_full", bank_full, 0);
    check("mid_rst_cena", ram_cena, 1);
    check("mid_rst_cenb", ram_cenb, 1);
    check("mid_rst_last", out_last, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    send(32, 100, 1);
    drain();
    check("fresh_bank", out_idx, 32);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/ram_pp_ctrl.md
Name: ram_pp_ctrl

Overview:
Ping-pong buffer controller that sits directly upstream of and around the dual-port RAM (ram_dp). It accepts a valid/ready word stream, writes it into one half (bank) of the RAM through port A, and streams completed banks back out through port B with a valid/ready interface. Both RAM ports run on the single block clock, so writing one bank and reading the other overlap.

Parameters:
Addr_Width, 6, RAM address width; bank select = MSB; bank depth D = 2^(Addr_Width-1) (default 32)
Word_Width, 32, data word width

Ports:
clk_i  in  1  clock; also drives clka/clkb of the RAM
rst_i  in  1  reset, asynchronous, active-high
in_valid_i  in  1  input word valid
in_ready_o  out  1  input word accepted when valid & ready
in_data_i  in  Word_Width  input word
out_valid_o  out  1  output word valid
out_ready_i  in  1  downstream accepts output word
out_data_o  out  Word_Width  output word
out_last_o  out  1  marks the final word (index D-1) of a bank
bank_full_o  out  2  per-bank full flags (status)
ram_cena_o  out  1  port A chip enable, active-low
ram_wena_o  out  1  port A write enable, active-low
ram_oena_o  out  1  port A output enable, active-low; tied 1
ram_addra_o  out  Addr_Width  port A address
ram_dataa_o  out  Word_Width  port A write data
ram_cenb_o  out  1  port B chip enable, active-low
ram_wenb_o  out  1  port B write enable, active-low; tied 1 (read only)
ram_oenb_o  out  1  port B output enable, active-low; tied 0
ram_addrb_o  out  Addr_Width  port B address
ram_datab_i  in  Word_Width  port B read data, valid 1 cycle after read issue

Behaviour:
- Reset (async, rst_i=1): wr_bank=0, wr_ptr=0, rd_bank=0, rd_ptr=0, full=2'b00, output buffer empty. Outputs: in_ready_o=0 while rst_i is high and 1 in the first cycle after release; out_valid_o=0, out_last_o=0, ram_cena_o=1, ram_wena_o=1, ram_cenb_o=1, addresses 0, ram_dataa_o=0. Reset mid-operation discards all buffered data and bank state.
- Write side: in_ready_o = ~full[wr_bank]. On accept: ram_cena_o=0, ram_wena_o=0, ram_addra_o={wr_bank, wr_ptr}, ram_dataa_o=in_data_i, all combinational in the accept cycle. wr_ptr increments; at wr_ptr=D-1 it wraps to 0, full[wr_bank] is set at the clock edge, and wr_bank toggles.
- Read side: 2-entry output buffer; occupancy plus in-flight reads must not exceed 2. A read issues when full[rd_bank]=1 and this capacity rule holds. On issue: ram_cenb_o=0, ram_addrb_o={rd_bank, rd_ptr}; the returned word enters the buffer the next cycle, tagged last if rd_ptr was D-1. Issuing the read at rd_ptr=D-1 clears full[rd_bank] at that edge, toggles rd_bank, and wraps rd_ptr to 0.
- Latency: read issue occurs at the earliest the cycle after full is set. First out_valid_o occurs 2 cycles after the edge that sets full, given an empty buffer. Sustained throughput is 1 word/cycle on both sides.
- Output: out_valid_o = buffer non-empty; out_data_o/out_last_o come from the buffer head; pop on out_valid_o & out_ready_i. Data order is strictly FIFO within and across banks.
- Boundaries:
  - Both banks full: in_ready_o=0 until the reader issues the last read of rd_bank. The freed bank is writable the next cycle.
  - Write and read never target the same bank, because writes use non-full banks and reads use full banks. Setting and clearing full in the same cycle always hits different banks.
  - Backpressure (out_ready_i=0) stalls read issue once the buffer plus in-flight reads reach 2. No word is lost or duplicated.
  - A partial bank is never output; it waits for D words.

Test Plan:
- Reset, write 32 words 0..31 back-to-back with out_ready_i=1 -> ram_wena_o low 32 cycles with addresses 0..31; bank_full_o=01; out words 0..31 in order, one per cycle; out_last_o only on 31; bank_full_o returns to 00.
- Continuous write of 96 words, out_ready_i=1 -> in_ready_o never drops; port A addresses 0..31, 32..63, 0..31; output equals input order; out_last_o on words 31, 63, 95.
- out_ready_i=0 while writing 64 words -> bank_full_o=11; in_ready_o=0 from word 64 onward; out_valid_o=1 holding word 0. Raise out_ready_i -> words 0..63 emerge with no loss or duplicate; in_ready_o returns 1 the cycle after the read of address 31 issues.
- Random out_ready_i (50%) and random in_valid_i over 1000 words -> scoreboard matches exactly; port A and port B addresses never share an MSB when both are enabled.
- Assert rst_i mid-bank (after 17 words written, 5 read) -> outputs immediately return to reset values; the next 32 words written output as a fresh bank starting at RAM address 0.
